// File: rtl/fft_pkg.sv
// Shared FFT constants and the trivial-twiddle select encodings used by the
// twiddle sequencer and the downstream bypass unit.
package fft_pkg;

    localparam int FFT_N  = 64;
    localparam int DATA_W = 32;

    // [2] swap real/imag, [1] negate real, [0] negate imag
    typedef enum logic [2:0] {
        TS_ONE  = 3'b000,
        TS_NEG  = 3'b011,
        TS_NEGJ = 3'b101,
        TS_POSJ = 3'b110
    } typesel_e;

    // Stages beyond the last one behave like the last stage.
    function automatic logic [2:0] clamp_stage(input logic [2:0] stage);
        return (stage > 3'd5) ? 3'd5 : stage;
    endfunction

endpackage

// File: rtl/tw_index_6b.sv
// Combinational twiddle index for a 64-point radix-2 DIF FFT: maps sample
// index n and stage to ROM address k and the trivial-twiddle select.
module tw_index_6b
    import fft_pkg::*;
(
    input  logic [5:0] n,
    input  logic [2:0] stage,
    output logic [4:0] k,
    output logic [2:0] typesel,
    output logic       trivial
);

    logic [2:0] s;
    logic [2:0] h;
    logic [4:0] mask;
    logic [4:0] masked;
    logic [4:0] k_raw;

    // Lower half of each butterfly group (bit h clear) always gets W^0.
    always_comb begin
        s      = clamp_stage(stage);
        h      = 3'd5 - s;
        mask   = (5'd1 << h) - 5'd1;
        masked = n[4:0] & mask;
        k_raw  = masked << s;
        k      = n[h] ? k_raw : 5'd0;
    end

    always_comb begin
        typesel = TS_ONE;
        trivial = 1'b0;
        if (k == 5'd0) begin
            typesel = TS_ONE;
            trivial = 1'b1;
        end else if (k == 5'd16) begin
            typesel = TS_NEGJ;
            trivial = 1'b1;
        end
    end

endmodule

// File: rtl/twiddle_seq_32b.sv
// Single-stage registered twiddle sequencer: tags each accepted sample with
// its twiddle address, trivial-twiddle select and end-of-frame flag.
module twiddle_seq_32b
    import fft_pkg::*;
#(
    parameter int N_LOG2 = 6
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic [2:0]        STAGE,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [2:0]        OUT_TYPESEL,
    output logic [4:0]        OUT_TWADDR,
    output logic              OUT_TRIVIAL,
    output logic              OUT_LAST,
    output logic              OUT_VALID,
    input  logic              OUT_READY
);

    logic [N_LOG2-1:0] n_q, n_d;
    logic [2:0]        frame_stage_q, frame_stage_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [2:0]        out_typesel_q, out_typesel_d;
    logic [4:0]        out_twaddr_q, out_twaddr_d;
    logic              out_trivial_q, out_trivial_d;
    logic              out_last_q, out_last_d;
    logic              out_valid_q, out_valid_d;

    logic              in_ready;
    logic              accept;
    logic [2:0]        cur_stage;
    logic [4:0]        tw_k;
    logic [2:0]        tw_typesel;
    logic              tw_trivial;

    tw_index_6b u_tw_index (
        .n       (n_q),
        .stage   (cur_stage),
        .k       (tw_k),
        .typesel (tw_typesel),
        .trivial (tw_trivial)
    );

    // The first sample of a frame already uses the STAGE value it brings in.
    always_comb begin
        in_ready      = !out_valid_q || OUT_READY;
        accept        = IN_VALID && in_ready;
        cur_stage     = (n_q == '0) ? STAGE : frame_stage_q;

        n_d           = n_q;
        frame_stage_d = frame_stage_q;
        out_data_d    = out_data_q;
        out_typesel_d = out_typesel_q;
        out_twaddr_d  = out_twaddr_q;
        out_trivial_d = out_trivial_q;
        out_last_d    = out_last_q;
        out_valid_d   = out_valid_q;

        if (accept) begin
            n_d           = n_q + 1'b1;
            frame_stage_d = cur_stage;
            out_data_d    = IN_DATA;
            out_typesel_d = tw_typesel;
            out_twaddr_d  = tw_k;
            out_trivial_d = tw_trivial;
            out_last_d    = (n_q == '1);
            out_valid_d   = 1'b1;
        end else if (OUT_READY) begin
            out_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            n_q           <= '0;
            frame_stage_q <= '0;
            out_data_q    <= '0;
            out_typesel_q <= '0;
            out_twaddr_q  <= '0;
            out_trivial_q <= 1'b0;
            out_last_q    <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            n_q           <= n_d;
            frame_stage_q <= frame_stage_d;
            out_data_q    <= out_data_d;
            out_typesel_q <= out_typesel_d;
            out_twaddr_q  <= out_twaddr_d;
            out_trivial_q <= out_trivial_d;
            out_last_q    <= out_last_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign IN_READY    = in_ready;
    assign OUT_DATA    = out_data_q;
    assign OUT_TYPESEL = out_typesel_q;
    assign OUT_TWADDR  = out_twaddr_q;
    assign OUT_TRIVIAL = out_trivial_q;
    assign OUT_LAST    = out_last_q;
    assign OUT_VALID   = out_valid_q;

endmodule

// File: tb/tb_twiddle_seq_32b.sv
// Scoreboard bench for twiddle_seq_32b: directed frames, backpressure, mid-frame
// reset and randomized handshakes checked against a behavioural twiddle model.
module tb_twiddle_seq_32b;

    logic        CLK;
    logic        RSTN;
    logic [2:0]  STAGE;
    logic [31:0] IN_DATA;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] OUT_DATA;
    logic [2:0]  OUT_TYPESEL;
    logic [4:0]  OUT_TWADDR;
    logic        OUT_TRIVIAL;
    logic        OUT_LAST;
    logic        OUT_VALID;
    logic        OUT_READY;

    twiddle_seq_32b #(.N_LOG2(6)) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .STAGE       (STAGE),
        .IN_DATA     (IN_DATA),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .OUT_DATA    (OUT_DATA),
        .OUT_TYPESEL (OUT_TYPESEL),
        .OUT_TWADDR  (OUT_TWADDR),
        .OUT_TRIVIAL (OUT_TRIVIAL),
        .OUT_LAST    (OUT_LAST),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY)
    );

    typedef struct {
        logic [31:0] data;
        int          k;
        logic [2:0]  ts;
        logic        triv;
        logic        last;
        int          n;
        int          s;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   modelN = 0;
    int   modelStage = 0;
    int   accepts = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=timeout required=completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Twiddle exponent straight from the DIF definition: W64^k with k derived from n and stage.
    function automatic void refTwiddle(input int n, input int st, output int k,
                                       output logic [2:0] ts, output logic triv);
        int s;
        int h;
        s = (st > 5) ? 5 : st;
        h = 5 - s;
        if (((n >> h) & 1) == 0) k = 0;
        else k = (n % (1 << h)) * (1 << s);
        if (k == 0) begin
            ts = 3'b000; triv = 1'b1;
        end else if (k == 16) begin
            ts = 3'b101; triv = 1'b1;
        end else begin
            ts = 3'b000; triv = 1'b0;
        end
    endfunction

    task automatic modelAccept(input logic [31:0] data, input logic [2:0] st);
        exp_t e;
        if (modelN == 0) modelStage = int'(st);
        e.data = data;
        e.n    = modelN;
        e.s    = (modelStage > 5) ? 5 : modelStage;
        refTwiddle(modelN, modelStage, e.k, e.ts, e.triv);
        e.last = (modelN == 63);
        expq.push_back(e);
        modelN = (modelN + 1) % 64;
        accepts++;
    endtask

    // One cycle of stimulus; the handshake is judged mid-cycle while inputs are stable.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [2:0] st,
                                 input logic ordy, output logic acc);
        @(negedge CLK);
        IN_VALID  = v;
        IN_DATA   = d;
        STAGE     = st;
        OUT_READY = ordy;
        #2;
        acc = IN_VALID && IN_READY;
        if (acc) modelAccept(IN_DATA, STAGE);
    endtask

    // Monitor: pops the scoreboard on each output handshake and checks hold stability.
    initial begin
        logic        holdPrev;
        logic [31:0] pData;
        logic [2:0]  pTs;
        logic [4:0]  pAddr;
        logic        pTriv;
        logic        pLast;
        exp_t        e;
        holdPrev = 1'b0;
        pData = '0; pTs = '0; pAddr = '0; pTriv = 1'b0; pLast = 1'b0;
        forever begin
            @(negedge CLK);
            #3;
            if (!RSTN) begin
                holdPrev = 1'b0;
            end else begin
                checkOutput("in_ready_rule", 32'(IN_READY), 32'(!OUT_VALID || OUT_READY));
                if (holdPrev) begin
                    checkOutput("hold_valid", 32'(OUT_VALID), 32'd1);
                    checkOutput("hold_data", OUT_DATA, pData);
                    checkOutput("hold_typesel", 32'(OUT_TYPESEL), 32'(pTs));
                    checkOutput("hold_twaddr", 32'(OUT_TWADDR), 32'(pAddr));
                    checkOutput("hold_trivial", 32'(OUT_TRIVIAL), 32'(pTriv));
                    checkOutput("hold_last", 32'(OUT_LAST), 32'(pLast));
                end
                if (OUT_VALID && OUT_READY) begin
                    if (expq.size() == 0) begin
                        checkOutput("unexpected_output", OUT_DATA, 32'hxxxxxxxx);
                    end else begin
                        e = expq.pop_front();
                        checkOutput("data", OUT_DATA, e.data);
                        checkOutput("twaddr", 32'(OUT_TWADDR), 32'(e.k));
                        checkOutput("typesel", 32'(OUT_TYPESEL), 32'(e.ts));
                        checkOutput("trivial", 32'(OUT_TRIVIAL), 32'(e.triv));
                        checkOutput("last", 32'(OUT_LAST), 32'(e.last));
                        if (e.s == 0 && e.n == 48) checkOutput("s0_n48_typesel", 32'(OUT_TYPESEL), 32'd5);
                        if (e.s == 0 && e.n == 33) checkOutput("s0_n33_twaddr", 32'(OUT_TWADDR), 32'd1);
                        if (e.s == 0 && e.n < 32)  checkOutput("s0_low_trivial", 32'(OUT_TRIVIAL), 32'd1);
                        if (e.s == 2 && e.n == 13) checkOutput("s2_n13_twaddr", 32'(OUT_TWADDR), 32'd20);
                        if (e.s == 5)              checkOutput("s5_trivial", 32'(OUT_TRIVIAL), 32'd1);
                    end
                end
                holdPrev = OUT_VALID && !OUT_READY;
                pData = OUT_DATA; pTs = OUT_TYPESEL; pAddr = OUT_TWADDR;
                pTriv = OUT_TRIVIAL; pLast = OUT_LAST;
            end
        end
    end

    initial begin
        logic acc;
        int   iter;
        RSTN = 1'b0; STAGE = '0; IN_DATA = '0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        #3;
        checkOutput("reset_valid", 32'(OUT_VALID), 32'd0);
        checkOutput("reset_data", OUT_DATA, 32'd0);
        checkOutput("reset_twaddr", 32'(OUT_TWADDR), 32'd0);
        checkOutput("reset_last", 32'(OUT_LAST), 32'd0);
        checkOutput("reset_in_ready", 32'(IN_READY), 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;

        $display("[TB] stage 0 frame, back-to-back");
        for (int i = 0; i < 64; i++) applyStimulus(1'b1, 32'h0100_0000 + 32'(i), 3'd0, 1'b1, acc);
        $display("[TB] stage 5 frame");
        for (int i = 0; i < 64; i++) applyStimulus(1'b1, 32'h0500_0000 + 32'(i), 3'd5, 1'b1, acc);
        $display("[TB] stage 2 frame with STAGE changed mid-frame");
        for (int i = 0; i < 64; i++)
            applyStimulus(1'b1, 32'h0200_0000 + 32'(i), (i < 6) ? 3'd2 : 3'd0, 1'b1, acc);
        applyStimulus(1'b0, 32'h0, 3'd0, 1'b1, acc);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'h1234_5678, 3'd1, 1'b0, acc);
        checkOutput("bp_first_accept", 32'(acc), 32'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'hCAFE_0001, 3'd1, 1'b0, acc);
            checkOutput("bp_in_ready", 32'(IN_READY), 32'd0);
        end
        iter = 0;
        while (modelN != 20 && iter < 100) begin
            applyStimulus(1'b1, $urandom, 3'(iter % 8), 1'b1, acc);
            iter++;
        end
        checkOutput("reach_n20", 32'(modelN), 32'd20);

        $display("[TB] reset mid-frame at n=20");
        @(negedge CLK);
        IN_VALID = 1'b0;
        #1;
        RSTN = 1'b0;
        #1;
        checkOutput("midreset_valid", 32'(OUT_VALID), 32'd0);
        checkOutput("midreset_in_ready", 32'(IN_READY), 32'd1);
        expq.delete();
        modelN = 0;
        @(negedge CLK);
        RSTN = 1'b1;

        $display("[TB] random handshakes over 10 frames");
        accepts = 0;
        iter = 0;
        while (accepts < 640 && iter < 6000) begin
            applyStimulus(($urandom % 4) != 0, $urandom, 3'($urandom % 8), ($urandom % 3) != 0, acc);
            iter++;
        end
        checkOutput("random_accepts", 32'(accepts), 32'd640);

        iter = 0;
        while (expq.size() != 0 && iter < 200) begin
            applyStimulus(1'b0, 32'h0, 3'd0, 1'b1, acc);
            iter++;
        end
        applyStimulus(1'b0, 32'h0, 3'd0, 1'b1, acc);
        checkOutput("drain_empty", 32'(expq.size()), 32'd0);
        checkOutput("drain_valid", 32'(OUT_VALID), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
